sram_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM between the instruction-fetch requester and the data-access requester.
- Sits between the IF-stage instruction port and the EXE-stage data port, and a unified memory.
- Uses per-cycle valid/ready acceptance and returns read data one cycle after acceptance.
- Data has priority over instruction fetch, with a bounded-starvation guarantee for instruction fetch.

---
 rtl/sram_arbiter_if.sv | 46 ++++
 rtl/sram_arbiter.sv | 95 +++++++++
 tb/tb_sram_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified single-port SRAM.
// Handshake: a request is accepted in any cycle where req && ready; ready is combinational
// and at most one of inst_ready/data_ready is high. Read data arrives with rvalid one cycle
// after acceptance, and rvalid has no backpressure.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ready;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ready;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_ready, inst_rvalid, inst_rdata,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_ready, data_rvalid, data_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_ready, inst_rvalid, inst_rdata,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_ready, data_rvalid, data_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Data-priority arbiter sharing one single-port SRAM between instruction fetch and data access.
// Optional perf counters are enabled with `define SRAM_ARB_PERF_EN.
module sram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  sram_arbiter_if.slave bus,
  output logic [1:0]    dbg_resp_state_o
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_inst_stall,
  output logic [31:0]   perf_data_grant
`endif
);

  typedef enum logic [1:0] {
    RESP_NONE    = 2'd0,
    RESP_INST_RD = 2'd1,
    RESP_DATA_RD = 2'd2
  } resp_state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  resp_state_e       resp_state_q, resp_state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              limit_hit;
  logic              grant_inst;
  logic              grant_data;
  logic [ADDR_W-1:0] mem_addr_w;
  logic [DATA_W-1:0] rdata_w;

  // Grants are gated by resetn so nothing reaches the SRAM while reset is held.
  always_comb begin
    limit_hit  = bus.inst_req && (starve_cnt_q == LIMIT);
    grant_data = resetn && bus.data_req && !limit_hit;
    grant_inst = resetn && bus.inst_req && !grant_data;

    resp_state_d = RESP_NONE;
    if (grant_inst) begin
      resp_state_d = RESP_INST_RD;
    end else if (grant_data && (bus.data_wen == 4'b0000)) begin
      resp_state_d = RESP_DATA_RD;
    end

    starve_cnt_d = starve_cnt_q;
    if (!bus.inst_req || grant_inst) begin
      starve_cnt_d = 4'd0;
    end else if (grant_data && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    mem_addr_w = grant_data ? bus.data_addr : bus.inst_addr;
    rdata_w    = bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_state_q <= RESP_NONE;
      starve_cnt_q <= 4'd0;
    end else begin
      resp_state_q <= resp_state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.inst_ready  = grant_inst;
  assign bus.data_ready  = grant_data;
  assign bus.mem_en      = grant_inst || grant_data;
  assign bus.mem_wen     = grant_data ? bus.data_wen : 4'b0000;
  assign bus.mem_addr    = mem_addr_w;
  assign bus.mem_wdata   = bus.data_wdata;

  assign bus.inst_rvalid = (resp_state_q == RESP_INST_RD);
  assign bus.data_rvalid = (resp_state_q == RESP_DATA_RD);
  assign bus.inst_rdata  = rdata_w;
  assign bus.data_rdata  = rdata_w;

  assign dbg_resp_state_o = resp_state_q;

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_inst_stall <= 32'd0;
      perf_data_grant <= 32'd0;
    end else begin
      if (bus.inst_req && !grant_inst) perf_inst_stall <= perf_inst_stall + 32'd1;
      if (grant_data)                  perf_data_grant <= perf_data_grant + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, hand sequences and random traffic
// against a rule-level arbitration model with a behavioural SRAM and a shadow memory.
module tb_sram_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic       clk;
  logic       resetn;
  logic [1:0] dbg_state;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_inst_stall;
  logic [31:0] perf_data_grant;
`endif

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .bus              (bus),
    .dbg_resp_state_o (dbg_state)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_inst_stall  (perf_inst_stall),
    .perf_data_grant  (perf_data_grant)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural SRAM device ----------------
  logic [31:0] sram [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      logic [31:0] w;
      w = sram.exists(bus.mem_addr) ? sram[bus.mem_addr] : init_word(bus.mem_addr);
      if (bus.mem_wen == 4'b0000) begin
        bus.mem_rdata <= w;
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wen[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
        sram[bus.mem_addr] = w;
      end
    end
  end

  // ---------------- reference shadow memory + scoreboard ----------------
  logic [31:0] shadow [logic [31:0]];
  logic [DW-1:0] exp_q[$];
  logic exp_inst_v;
  logic exp_data_v;
  int   checks;
  int   failures;
  int   model_starve;

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  task automatic shadow_wr(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd);
    logic [31:0] w;
    w = shadow_rd(a);
    for (int b = 0; b < 4; b++)
      if (wen[b]) w[8*b +: 8] = wd[8*b +: 8];
    shadow[a] = w;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_wen   = 4'b0000;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
  endtask

  // One cycle, entered just after a negedge: check last cycle's responses, drive, check grant.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                       input logic e_ir, input logic e_dr, input string tag);
    logic [31:0] ed;
    check({tag, " inst_rvalid"}, 32'(bus.inst_rvalid), 32'(exp_inst_v));
    check({tag, " data_rvalid"}, 32'(bus.data_rvalid), 32'(exp_data_v));
    if (exp_inst_v || exp_data_v) begin
      ed = exp_q.pop_front();
      if (exp_inst_v) check({tag, " inst_rdata"}, bus.inst_rdata, ed);
      else            check({tag, " data_rdata"}, bus.data_rdata, ed);
    end
    bus.inst_req   = ir;
    bus.inst_addr  = ia;
    bus.data_req   = dr;
    bus.data_wen   = wen;
    bus.data_addr  = da;
    bus.data_wdata = wd;
    #1;
    check({tag, " inst_ready"}, 32'(bus.inst_ready), 32'(e_ir));
    check({tag, " data_ready"}, 32'(bus.data_ready), 32'(e_dr));
    check({tag, " mem_en"}, 32'(bus.mem_en), 32'(e_ir || e_dr));
    if (e_dr) begin
      check({tag, " mem_addr"}, bus.mem_addr, da);
      check({tag, " mem_wen"}, 32'(bus.mem_wen), 32'(wen));
      if (wen != 4'b0000) check({tag, " mem_wdata"}, bus.mem_wdata, wd);
    end else if (e_ir) begin
      check({tag, " mem_addr"}, bus.mem_addr, ia);
      check({tag, " mem_wen"}, 32'(bus.mem_wen), 32'd0);
    end
    exp_inst_v = e_ir;
    exp_data_v = e_dr && (wen == 4'b0000);
    if (e_ir)            exp_q.push_back(shadow_rd(ia));
    else if (exp_data_v) exp_q.push_back(shadow_rd(da));
    if (e_dr && (wen != 4'b0000)) shadow_wr(da, wen, wd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    exp_inst_v   = 1'b0;
    exp_data_v   = 1'b0;
    exp_q.delete();
    model_starve = 0;
    repeat (2) @(negedge clk);
    bus.inst_req = 1'b1;
    bus.data_req = 1'b1;
    #1;
    check("rst inst_ready", 32'(bus.inst_ready), 32'd0);
    check("rst data_ready", 32'(bus.data_ready), 32'd0);
    check("rst mem_en", 32'(bus.mem_en), 32'd0);
    check("rst rvalids", {30'd0, bus.inst_rvalid, bus.data_rvalid}, 32'd0);
    check("rst resp_state", 32'(dbg_state), 32'd0);
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ir;
    logic        dr;
    logic [3:0]  wen;
    logic [31:0] da;
    logic        e_ir;
    logic        e_dr;
  } vec_t;

  vec_t vecs [20];

  initial begin
    logic ir, dr, e_ir, e_dr, last_ia, last_da;
    logic [31:0] ia, da, wd;
    logic [3:0]  wen;

    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bus.mem_rdata = '0;
    idle_inputs();

    // Conflict D,D,D,D,I,D,D,D, a write, starve reset when inst drops, then a full re-starve.
    vecs[0]  = '{1'b0, 1'b0, 4'h0, 32'h200, 1'b0, 1'b0};
    for (int i = 1; i <= 4; i++)  vecs[i] = '{1'b1, 1'b1, 4'h0, 32'h200 + 32'(4*i), 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 4'h0, 32'h214, 1'b1, 1'b0};
    for (int i = 6; i <= 8; i++)  vecs[i] = '{1'b1, 1'b1, 4'h0, 32'h200 + 32'(4*i), 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 4'h3, 32'h100, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 4'h0, 32'h228, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 4'h0, 32'h22C, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 4'h0, 32'h100, 1'b0, 1'b1};
    for (int i = 13; i <= 16; i++) vecs[i] = '{1'b1, 1'b1, 4'h0, 32'h200 + 32'(4*i), 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 4'h0, 32'h244, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 4'h0, 32'h248, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 4'h0, 32'h24C, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(vecs[i].ir, 32'h1C00_0000 + 32'(4*i), vecs[i].dr, vecs[i].wen, vecs[i].da,
            32'hDEAD_BEEF, vecs[i].e_ir, vecs[i].e_dr, $sformatf("vec%0d", i));

    // Inst only: three back-to-back fetches of the same address.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h1C00_0000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, "inst_only");

    // Readback of the half-word write.
    cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 1'b1, "rd_0x100");
    check("rd_0x100 low half", 32'(bus.data_rdata[15:0]), 32'h0000_BEEF);
    cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, "drain");

    // Reset while a data read response is in flight.
    cycle(1'b0, 32'h0, 1'b1, 4'h0, 32'h104, 32'h0, 1'b0, 1'b1, "rst_rd accept");
    check("rst_rd rvalid before reset", 32'(bus.data_rvalid), 32'd1);
    #2;
    resetn = 1'b0;
    idle_inputs();
    #1;
    check("rst_rd rvalid in reset", 32'(bus.data_rvalid), 32'd0);
    check("rst_rd state in reset", 32'(dbg_state), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_inst_v   = 1'b0;
    exp_data_v   = 1'b0;
    exp_q.delete();
    model_starve = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, "rst_rd post");

`ifdef SRAM_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) check("perf_inst_stall at inst grant", perf_inst_stall, 32'd4);
      cycle(1'b1, 32'h1C00_0000, 1'b1, 4'h0, 32'h300 + 32'(4*i), 32'h0,
            i == 4, i != 4, "perf_conflict");
    end
    check("perf_data_grant after 8", perf_data_grant, 32'd7);
    check("perf_inst_stall after 8", perf_inst_stall, 32'd7);
`endif

    // Randomized traffic against the rule-level model.
    do_reset();
    ir = 1'b0; dr = 1'b0; last_ia = 1'b1; last_da = 1'b1;
    ia = '0; da = '0; wd = '0; wen = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ir || last_ia) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = 32'h1C00_0000 + 32'(4 * $urandom_range(0, 31));
      end
      if (!dr || last_da) begin
        dr  = ($urandom_range(0, 3) != 0);
        wen = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        da  = 32'h100 + 32'(4 * $urandom_range(0, 15));
        wd  = $urandom;
      end
      // Data wins unless inst has already waited through LIMIT data grants.
      e_dr = dr && !(ir && (model_starve >= LIMIT));
      e_ir = ir && !e_dr;
      cycle(ir, ia, dr, wen, da, wd, e_ir, e_dr, "rand");
      if (e_ir || !ir)  model_starve = 0;
      else if (e_dr)    model_starve = (model_starve + 1 > LIMIT) ? LIMIT : model_starve + 1;
      last_ia = e_ir;
      last_da = e_dr;
    end
    cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, "final drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
